// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared types and constants for the SPI nibble command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    localparam int c_NIBBLE_WIDTH = 4;
    localparam int c_NUM_REGS     = 4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [0:0] {
        IDLE         = 1'b0,
        WAIT_OPERAND = 1'b1
    } state_t;

    // Zero-extended add so the carry lands in bit 4.
    function automatic logic [c_NIBBLE_WIDTH:0] add_nibbles(
        input logic [c_NIBBLE_WIDTH-1:0] a,
        input logic [c_NIBBLE_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_timeout_timer
// Description : Counts enabled cycles; expired flags the final count cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                c_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [c_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_WIDTH'(1);
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_nibble_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_nibble_cmd_ctrl
// Description : Frames SPI nibbles into commands and executes them on a
//               four-entry 4-bit register bank with an inter-nibble timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_nibble_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  nibble_in,
    input  logic        nibble_valid,
    output logic [15:0] regs_out,
    output logic        carry_flag,
    output logic        busy,
    output logic        cmd_done,
    output logic        err_timeout,
    output logic        timeout_sticky,
    output logic [7:0]  cmd_count
);

    state_t                    r_state;
    logic [1:0]                r_cmd;
    logic [1:0]                r_addr;
    logic [c_NIBBLE_WIDTH-1:0] r_regs [c_NUM_REGS];

    logic [1:0]                w_op_cmd;
    logic [1:0]                w_op_addr;
    logic [c_NIBBLE_WIDTH:0]   w_sum;
    logic                      w_expired;
    logic                      w_timer_clear;
    logic                      w_timer_enable;

    assign w_op_cmd       = nibble_in[3:2];
    assign w_op_addr      = nibble_in[1:0];
    assign w_sum          = add_nibbles(r_regs[r_addr], nibble_in);
    assign w_timer_clear  = (r_state == IDLE);
    assign w_timer_enable = (r_state == WAIT_OPERAND);

    nibble_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .expired (w_expired)
    );

    generate
        for (genvar k = 0; k < c_NUM_REGS; k++) begin : g_regs_out
            assign regs_out[k*c_NIBBLE_WIDTH +: c_NIBBLE_WIDTH] = r_regs[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cmd          <= OP_NOP;
            r_addr         <= '0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            carry_flag     <= 1'b0;
            busy           <= 1'b0;
            cmd_done       <= 1'b0;
            err_timeout    <= 1'b0;
            timeout_sticky <= 1'b0;
            cmd_count      <= '0;
        end else begin
            cmd_done    <= 1'b0;
            err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (nibble_valid) begin
                        case (w_op_cmd)
                            OP_NOP: begin
                                cmd_done  <= 1'b1;
                                cmd_count <= cmd_count + 8'd1;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < c_NUM_REGS; i++) begin
                                    r_regs[i] <= '0;
                                end
                                carry_flag     <= 1'b0;
                                timeout_sticky <= 1'b0;
                                cmd_done       <= 1'b1;
                                cmd_count      <= cmd_count + 8'd1;
                            end
                            OP_WRITE, OP_ADD: begin
                                r_cmd   <= w_op_cmd;
                                r_addr  <= w_op_addr;
                                busy    <= 1'b1;
                                r_state <= WAIT_OPERAND;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_OPERAND: begin
                    // A valid operand on the final count cycle wins over the timeout.
                    if (nibble_valid) begin
                        if (r_cmd == OP_ADD) begin
                            r_regs[r_addr] <= w_sum[c_NIBBLE_WIDTH-1:0];
                            carry_flag     <= w_sum[c_NIBBLE_WIDTH];
                        end else begin
                            r_regs[r_addr] <= nibble_in;
                        end
                        cmd_done  <= 1'b1;
                        cmd_count <= cmd_count + 8'd1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_expired) begin
                        err_timeout    <= 1'b1;
                        timeout_sticky <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_nibble_cmd_ctrl.md
# spi_nibble_cmd_ctrl

Command sequencer that sits directly downstream of the SPI slave receiver. It takes the 4-bit words and one-cycle valid strobes the receiver produces, frames them into one- or two-nibble commands, and executes them on a bank of four 4-bit registers that drive the board outputs. It also enforces an inter-nibble timeout and reports completion and error status to the rest of the FPGA controller.

## Interface
- TIMEOUT_CYCLES, 1_000_000: clk cycles allowed between opcode and operand nibble; must be ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- nibble_in  in  4  received data word; sampled only when nibble_valid is high.
- nibble_valid  in  1  one-cycle strobe marking a new nibble.
- regs_out  out  16  register bank; reg k occupies bits [4k+3:4k].
- carry_flag  out  1  carry out of the last ADD.
- busy  out  1  high while waiting for an operand.
- cmd_done  out  1  one-cycle pulse per completed command.
- err_timeout  out  1  one-cycle pulse when a frame is abandoned.
- timeout_sticky  out  1  set by any timeout; cleared only by CLEAR or reset.
- cmd_count  out  8  count of completed commands; wraps 255→0.

## Operation
- Opcode nibble format: [3:2] = cmd, [1:0] = reg address A.
- cmd 00, NOP: completes on the opcode nibble; changes nothing.
- cmd 11, CLEAR: completes on the opcode nibble. All registers, carry_flag and timeout_sticky go to 0.
- cmd 01, WRITE: the next nibble is the operand; reg[A] ← operand.
- cmd 10, ADD: the next nibble is the operand; {carry_flag, reg[A]} ← reg[A] + operand (5-bit result). The register keeps 4 bits, so it wraps modulo 16.
- FSM states: IDLE and WAIT_OPERAND.
  - IDLE + valid with cmd 01/10: latch cmd and A, clear the timeout counter, go to WAIT_OPERAND.
  - IDLE + valid with cmd 00/11: execute and stay in IDLE.
  - WAIT_OPERAND + valid: execute and go to IDLE.
  - WAIT_OPERAND with counter = TIMEOUT_CYCLES-1 and no valid: go to IDLE, pulse err_timeout, set timeout_sticky. The latched command is discarded and no register changes.
- Boundary: a valid nibble arriving in the same cycle as the final count is taken as the operand, and no timeout occurs.
- A timeout followed by a new nibble: that nibble is decoded as an opcode.
- cmd_count increments on every cmd_done, not on timeouts.
- WRITE does not change carry_flag.

## Timing
- Reset values: regs_out 0, carry_flag 0, busy 0, cmd_done 0, err_timeout 0, timeout_sticky 0, cmd_count 0, FSM in IDLE, timeout counter 0.
- Assertion of reset_n low mid-frame aborts the frame immediately. No cmd_done or err_timeout is issued.
- All outputs are registered.
- Register, carry and cmd_count updates, and the cmd_done pulse, all appear on the edge after the cycle in which the completing nibble_valid is high (1-cycle latency).
- busy rises on the edge after the opcode strobe. It falls together with the cmd_done or err_timeout pulse.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and increments every cycle in WAIT_OPERAND. err_timeout fires exactly TIMEOUT_CYCLES cycles after busy rises.
- Back-to-back valid strobes in consecutive cycles are legal and are each processed; there is no drop or stall.

## Structure
- Shared package spi_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_OPERAND);
  - opcode localparams OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_ADD = 2'b10, OP_CLEAR = 2'b11;
  - the nibble width constant 4 and register count 4.
- One sub-module: nibble_timeout_timer (inputs: clear, enable; output: expired). It is parameterised by TIMEOUT_CYCLES and instantiated once.
- Everything else (FSM, register bank, adder) lives in the top module.

## Test plan
- Reset, then strobe 0x5 followed by 0xA: reg1 = 0xA, cmd_done once, cmd_count = 1, carry_flag = 0.
- After the previous case, strobe 0x9 followed by 0x7: reg1 = 0x1 (0xA + 0x7 = 0x11), carry_flag = 1, cmd_count = 2.
- With TIMEOUT_CYCLES = 8, strobe 0x6 and no operand: err_timeout pulses 8 cycles after busy rises, timeout_sticky = 1, regs unchanged. A following strobe of 0xC (CLEAR) zeroes all registers and timeout_sticky.
- With TIMEOUT_CYCLES = 8, deliver the operand exactly on the final count cycle: the write completes and err_timeout stays 0.
- Strobe 0x4, 0x3, 0x0 in consecutive cycles: reg0 = 0x3, then the NOP completes; two cmd_done pulses in consecutive cycles.
- Drive reset_n low while busy: all outputs return to reset values at once, and the next nibble is decoded as an opcode.
